// File: rtl/core_timer0.sv
// TMR0: 8-bit timer with a synchronized external clock pin, an 8-bit prescaler,
// a post-write increment inhibit and a one-clk overflow pulse.
module core_timer0 #(
    parameter logic [7:0] RESET_VALUE = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cycle_en,
    input  logic       wr_en,
    input  logic [7:0] d,
    output logic [7:0] q,
    input  logic       option_t0cs,
    input  logic       option_t0se,
    input  logic       option_psa,
    input  logic [2:0] option_ps,
    input  logic       t0cki,
    output logic       intcon_t0if_set_en
);

    logic       sync0;
    logic       sync1;
    logic       sync_d;
    logic [7:0] pre;
    logic [7:0] ps_mask;
    logic [1:0] inhibit;
    logic       ovf;
    logic       ext_tick;
    logic       src_tick;
    logic       inc_tick;
    logic       hold;
    logic       bump;

    always_comb begin
        ext_tick = option_t0se ? (sync_d & ~sync1) : (sync1 & ~sync_d);
        src_tick = option_t0cs ? ext_tick : cycle_en;
        // Low (ps+1) bits all ones marks the last tick of a prescaler period.
        ps_mask  = 8'hFF >> (3'd7 - option_ps);
        inc_tick = option_psa ? src_tick
                              : (src_tick && ((pre & ps_mask) == ps_mask));
        hold     = (inhibit != 2'd0);
        bump     = inc_tick && !hold && !wr_en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sync_d  <= 1'b0;
            q       <= RESET_VALUE;
            pre     <= 8'd0;
            inhibit <= 2'd0;
            ovf     <= 1'b0;
        end else begin
            sync0  <= t0cki;
            sync1  <= sync0;
            sync_d <= sync1;

            if (wr_en) begin
                inhibit <= 2'd2;
            end else if (cycle_en && hold) begin
                inhibit <= inhibit - 2'd1;
            end

            if (wr_en) begin
                q <= d;
                if (!option_psa) begin
                    pre <= 8'd0;
                end
            end else begin
                if (bump) begin
                    q <= q + 8'd1;
                end
                if (!option_psa && src_tick && !hold) begin
                    pre <= pre + 8'd1;
                end
            end

            // Only a genuine FF->00 increment raises the flag; writes never do.
            ovf <= bump && (q == 8'hFF);
        end
    end

    assign intcon_t0if_set_en = ovf;

endmodule

// File: tb/tb_core_timer0.sv
// Scoreboard bench for core_timer0: stimulus queues expected q changes and
// overflow pulses, a monitor pops and compares each observed event.
module tb_core_timer0;

    logic       clk;
    logic       rst;
    logic       cycle_en;
    logic       wr_en;
    logic [7:0] d;
    logic [7:0] q;
    logic       option_t0cs;
    logic       option_t0se;
    logic       option_psa;
    logic [2:0] option_ps;
    logic       t0cki;
    logic       intcon_t0if_set_en;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    logic [8:0] exp_q[$];

    core_timer0 dut (
        .clk               (clk),
        .rst               (rst),
        .cycle_en          (cycle_en),
        .wr_en             (wr_en),
        .d                 (d),
        .q                 (q),
        .option_t0cs       (option_t0cs),
        .option_t0se       (option_t0se),
        .option_psa        (option_psa),
        .option_ps         (option_ps),
        .t0cki             (t0cki),
        .intcon_t0if_set_en(intcon_t0if_set_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_q(input logic [7:0] v);
        exp_q.push_back({1'b0, v});
    endtask

    task automatic expect_p();
        exp_q.push_back({1'b1, 8'h00});
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic mon_event(input logic p, input logic [7:0] v);
        logic [8:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected event pulse=%0d q=%h at %0t", p, v, $time);
        end else begin
            e = exp_q.pop_front();
            if (e !== {p, v}) begin
                errors++;
                $display("FAIL scoreboard actual pulse=%0d q=%h required pulse=%0d q=%h at %0t",
                         p, v, e[8], e[7:0], $time);
            end
        end
    endtask

    initial begin
        logic [7:0] prev;
        wait (mon_on);
        prev = q;
        forever begin
            @(negedge clk);
            if (q !== prev) begin
                mon_event(1'b0, q);
                prev = q;
            end
            if (intcon_t0if_set_en !== 1'b0) begin
                mon_event(1'b1, 8'h00);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic ce, input logic we, input logic [7:0] dd);
        cycle_en = ce;
        wr_en    = we;
        d        = dd;
        @(posedge clk);
        #1;
        cycle_en = 1'b0;
        wr_en    = 1'b0;
    endtask

    initial begin
        logic [7:0] ev;
        rst         = 1'b0;
        cycle_en    = 1'b0;
        wr_en       = 1'b0;
        d           = 8'h00;
        option_t0cs = 1'b1;
        option_t0se = 1'b0;
        option_psa  = 1'b1;
        option_ps   = 3'd0;
        t0cki       = 1'b1;

        // Reset state, t0cki held high through reset.
        clks(3);
        chk("reset q", q, 8'h00);
        chk("reset pulse", {7'd0, intcon_t0if_set_en}, 8'h00);
        #3;
        rst    = 1'b1;
        mon_on = 1'b1;
        expect_q(8'h01);
        clks(2);
        chk("post-reset rise not yet", q, 8'h00);
        clks(1);
        chk("post-reset rise tick", q, 8'h01);

        option_t0cs = 1'b0;
        t0cki       = 1'b0;

        // Internal 1:1 overflow.
        expect_q(8'hFD);
        cyc(1'b0, 1'b1, 8'hFD);
        expect_q(8'hFE);
        expect_q(8'hFF);
        expect_q(8'h00);
        expect_p();
        expect_q(8'h01);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (i == 4) chk("overflow pulse high", {7'd0, intcon_t0if_set_en}, 8'h01);
            cyc(1'b0, 1'b0, 8'h00);
            if (i == 4) chk("overflow pulse one clk", {7'd0, intcon_t0if_set_en}, 8'h00);
            cyc(1'b0, 1'b0, 8'h00);
            cyc(1'b0, 1'b0, 8'h00);
        end

        // Prescaler 1:8.
        option_psa = 1'b0;
        option_ps  = 3'd2;
        expect_q(8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        expect_q(8'h01);
        expect_q(8'h02);
        expect_q(8'h03);
        repeat (26) cyc(1'b1, 1'b0, 8'h00);
        chk("prescale 1:8 q", q, 8'h03);
        chk("prescale count", dut.pre, 8'd24);

        // Write versus tick collision.
        option_psa = 1'b1;
        expect_q(8'hFF);
        cyc(1'b0, 1'b1, 8'hFF);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        expect_q(8'h10);
        cyc(1'b1, 1'b1, 8'h10);
        chk("collision write wins", q, 8'h10);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("collision inhibit", q, 8'h10);
        expect_q(8'h11);
        cyc(1'b1, 1'b0, 8'h00);
        chk("collision resume", q, 8'h11);

        // External falling edge.
        option_t0cs = 1'b1;
        option_t0se = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ev = 8'h12 + 8'(i);
            expect_q(ev);
            t0cki = 1'b1;
            clks(4);
            #3;
            t0cki = 1'b0;
            clks(2);
            chk("ext edge before 3 clks", q, ev - 8'd1);
            clks(1);
            chk("ext edge at 3 clks", q, ev);
            clks(2);
        end
        option_t0cs = 1'b0;
        option_t0se = 1'b0;

        // Reset mid-operation.
        option_psa = 1'b0;
        option_ps  = 3'd7;
        expect_q(8'h7A);
        cyc(1'b0, 1'b1, 8'h7A);
        repeat (7) cyc(1'b1, 1'b0, 8'h00);
        chk("pre-reset prescaler", dut.pre, 8'd5);
        expect_q(8'h00);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset q", q, 8'h00);
        chk("async reset prescaler", dut.pre, 8'h00);
        chk("async reset pulse", {7'd0, intcon_t0if_set_en}, 8'h00);
        clks(2);
        #3;
        rst = 1'b1;
        clks(6);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing events actual %0d pending required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_timer0.md
CORE_TIMER0 -- requirements
Module: core_timer0

Interface
REQ-001 The block SHALL have one parameter: RESET_VALUE, default 8'd0, the TMR0 value loaded on reset.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- cycle_en  input  1  instruction-cycle strobe; high for one clk per instruction cycle.
- wr_en  input  1  core write strobe for the TMR0 register.
- d  input  8  write data.
- q  output  8  current TMR0 count.
- option_t0cs  input  1  clock source select: 0 = cycle_en, 1 = external pin.
- option_t0se  input  1  external edge select: 0 = rising, 1 = falling.
- option_psa  input  1  prescaler assignment: 1 = WDT, giving TMR0 a 1:1 rate; 0 = TMR0.
- option_ps  input  3  prescaler select.
- t0cki  input  1  raw, asynchronous external clock pin.
- intcon_t0if_set_en  output  1  one-clk overflow pulse; drives the INTCON T0IF set input.

Function
REQ-003 t0cki SHALL pass through a 2-flop synchronizer, then a 1-flop edge detector; ext_tick SHALL be a one-clk pulse on the selected edge of the synchronized signal.
REQ-004 Source tick src_tick SHALL equal cycle_en when option_t0cs=0, and ext_tick when option_t0cs=1.
REQ-005 When option_psa=0, an 8-bit prescaler counter SHALL increment on each src_tick.
REQ-006 When option_psa=0, inc_tick SHALL assert on any src_tick for which the prescaler's low (option_ps+1) bits are all ones, giving a ratio of 2^(option_ps+1) (1:2 to 1:256).
REQ-007 The prescaler SHALL wrap modulo 256 and hold when option_psa=1.
REQ-008 When option_psa=1, inc_tick SHALL equal src_tick.
REQ-009 On inc_tick with no write and no inhibit, q SHALL increment by 1, modulo 256.
REQ-010 On the edge where q goes 8'hFF to 8'h00 by increment, a registered flag SHALL be set so that intcon_t0if_set_en is high for exactly the next clk cycle only.
REQ-011 On wr_en, q SHALL load d on the next edge, and wr_en SHALL take priority over a coincident inc_tick.
REQ-012 A write SHALL produce no overflow pulse, including when d=8'h00 or q was 8'hFF.
REQ-013 On wr_en, if option_psa=0, the prescaler SHALL clear to 0 on the same edge.
REQ-014 On wr_en, a 2-bit inhibit counter SHALL load 2.
REQ-015 The inhibit counter SHALL decrement on each cycle_en while nonzero, including in external-source mode.
REQ-016 While the inhibit counter is nonzero, inc_tick SHALL be ignored by q and the prescaler SHALL hold.
REQ-017 A write during an active inhibit SHALL reload the inhibit counter to 2.
REQ-018 Changing option_ps or option_psa SHALL take effect on the next src_tick, with no implicit prescaler clear.
REQ-019 Changing option_t0cs or option_t0se SHALL take effect the same cycle, and a spurious tick caused by the change SHALL be accepted.

Reset
REQ-020 While rst=0, the block SHALL asynchronously force: q=RESET_VALUE, prescaler=0, inhibit=0, synchronizer and edge flops=0, intcon_t0if_set_en=0.
REQ-021 After rst releases, a t0cki held high through reset SHALL produce one rising ext_tick 3 clks later (documented behaviour).
REQ-022 Assertion of rst mid-count or mid-inhibit SHALL discard all state, and no overflow pulse SHALL be emitted.

Verification
REQ-023 Internal 1:1 overflow: psa=1, t0cs=0, write d=8'hFD, cycle_en every 4 clks.
- Response: after the 2 inhibited cycles, q steps FE, FF, 00.
- Response: intcon_t0if_set_en is high for exactly one clk after the FF to 00 edge.
REQ-024 Prescaler 1:8: psa=0, ps=3'd2, q=0, cycle_en continuous. Response: q increments once every 8 cycle_en ticks; q=3 after 24 ticks after inhibit expiry.
REQ-025 Write versus tick collision: q=8'hFF, wr_en with d=8'h10 on the same clk as inc_tick.
- Response: q=8'h10 and no pulse.
- Response: the next 2 cycle_en ticks do not increment q.
REQ-026 External falling edge: t0cs=1, t0se=1, psa=1, 5 falling edges on t0cki. Response: q advances by 5, each increment 3 clks after its falling edge, and rising edges have no effect.
REQ-027 Reset mid-operation: pull rst low asynchronously between clk edges while q=8'h7A and the prescaler is nonzero.
- Response: q=RESET_VALUE immediately.
- Response: the prescaler reads 0.
- Response: no pulse occurs after release.
